ble_frame_rx: RTL and testbench

Parametrised, length-framed packet receiver that sits between `uart_rx` and the flight-control registers in the BLE command path. It hunts for a sync byte, checks a length byte, and assembles `NUM_FIELDS` multi-byte fields into a shadow buffer. An optional checksum is verified before anything is committed. Fields are committed atomically with a one-cycle `frame_valid` pulse. Malformed, corrupted or stalled frames are dropped, flagged and counted, and never disturb the previously committed values.

---
 rtl/ble_frame_rx.sv | 217 +++++++++++++++++++++
 tb/tb_ble_frame_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ble_frame_rx.sv
// ble_frame_rx -- length-framed packet receiver for the BLE command path.
//
// Hunts for SYNC_BYTE, checks the LEN byte, assembles NUM_FIELDS fields of
// FIELD_BYTES bytes (first byte = MSB) into a shadow buffer and commits them
// atomically to `fields` with a one-cycle frame_valid pulse. Bad length,
// bad checksum and inter-byte timeouts drop the frame, pulse an error flag
// and bump err_count without touching the committed fields.
//
// Optional feature macro: BLE_FRAME_CHECKSUM_EN
//   defined   -> frame ends with CHK = XOR(LEN, payload); err_chk active.
//   undefined -> no CHK byte, commit on the last payload byte; err_chk = 0.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   rx_byte      in   [7:0] byte from uart_rx, sampled when rx_valid=1
//   rx_valid     in   one-cycle byte strobe
//   fields       out  [NUM_FIELDS-1:0][8*FIELD_BYTES-1:0] committed fields
//   frame_valid  out  one-cycle pulse on commit
//   err_len      out  one-cycle pulse, LEN mismatch
//   err_chk      out  one-cycle pulse, checksum mismatch
//   err_timeout  out  one-cycle pulse, inter-byte timeout
//   busy         out  high whenever the FSM is not hunting for sync
//   frame_count  out  [15:0] good frames, wrapping
//   err_count    out  [15:0] errors, saturating
module ble_frame_rx #(
    parameter int         NUM_FIELDS   = 10,
    parameter int         FIELD_BYTES  = 1,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 100_000
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [7:0]                              rx_byte,
    input  logic                                    rx_valid,
    output logic [NUM_FIELDS-1:0][8*FIELD_BYTES-1:0] fields,
    output logic                                    frame_valid,
    output logic                                    err_len,
    output logic                                    err_chk,
    output logic                                    err_timeout,
    output logic                                    busy,
    output logic [15:0]                             frame_count,
    output logic [15:0]                             err_count
);

    localparam int P    = NUM_FIELDS * FIELD_BYTES;
    localparam int IDXW = (P > 1) ? $clog2(P) : 1;
    localparam int CNTW = $clog2(TIMEOUT_CLKS);

    localparam logic [7:0]      LEN_VAL  = 8'(P % 256);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(P - 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT_CLKS - 1);

`ifdef BLE_FRAME_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHK     = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;
`endif

    state_t                                  state_q;
    logic [IDXW-1:0]                         idx_q;
    logic [CNTW-1:0]                         cnt_q;
    logic [P-1:0][7:0]                       shadow_q;
    logic [NUM_FIELDS-1:0][8*FIELD_BYTES-1:0] fields_q;
    logic                                    frame_valid_q;
    logic                                    err_len_q;
    logic                                    err_chk_q;
    logic                                    err_timeout_q;
    logic [15:0]                             frame_count_q;
    logic [15:0]                             err_count_q;
`ifdef BLE_FRAME_CHECKSUM_EN
    logic [7:0]                              xor_q;
`endif

    // Per-cycle events, all decoded from current state and the input strobe.
    logic timeout_d;
    logic len_err_d;
    logic chk_err_d;
    logic commit_d;
    logic any_err_d;
    logic last_byte_d;
    logic use_rx_last;

    always_comb begin
        timeout_d   = (state_q != ST_HUNT) && !rx_valid && (cnt_q == CNT_LAST);
        len_err_d   = rx_valid && (state_q == ST_LEN) && (rx_byte != LEN_VAL);
        last_byte_d = (state_q == ST_PAYLOAD) && (idx_q == IDX_LAST);
`ifdef BLE_FRAME_CHECKSUM_EN
        chk_err_d   = rx_valid && (state_q == ST_CHK) && (rx_byte != xor_q);
        commit_d    = rx_valid && (state_q == ST_CHK) && (rx_byte == xor_q);
`else
        chk_err_d   = 1'b0;
        commit_d    = rx_valid && last_byte_d;
`endif
        any_err_d   = timeout_d || len_err_d || chk_err_d;
        // Without a CHK byte, the commit edge is also the edge that samples
        // the last payload byte, so that byte is taken straight from rx_byte.
        use_rx_last = (state_q == ST_PAYLOAD);
    end

    // Shadow buffer reshaped into field order: byte b belongs to field
    // b/FIELD_BYTES, and the first byte of a field is its MSB.
    logic [NUM_FIELDS-1:0][8*FIELD_BYTES-1:0] commit_fields;

    generate
        for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
            for (genvar gj = 0; gj < FIELD_BYTES; gj++) begin : g_byte
                localparam int B = gi * FIELD_BYTES + gj;
                if (B == P - 1) begin : g_last
                    assign commit_fields[gi][8*(FIELD_BYTES-gj)-1 -: 8] =
                        use_rx_last ? rx_byte : shadow_q[B];
                end else begin : g_mid
                    assign commit_fields[gi][8*(FIELD_BYTES-gj)-1 -: 8] = shadow_q[B];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_HUNT;
            idx_q         <= '0;
            cnt_q         <= '0;
            shadow_q      <= '0;
            fields_q      <= '0;
            frame_valid_q <= 1'b0;
            err_len_q     <= 1'b0;
            err_chk_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            frame_count_q <= '0;
            err_count_q   <= '0;
`ifdef BLE_FRAME_CHECKSUM_EN
            xor_q         <= '0;
`endif
        end else begin
            frame_valid_q <= commit_d;
            err_len_q     <= len_err_d;
            err_chk_q     <= chk_err_d;
            err_timeout_q <= timeout_d;

            if (commit_d) begin
                fields_q      <= commit_fields;
                frame_count_q <= frame_count_q + 16'd1;
            end

            if (any_err_d && (err_count_q != 16'hFFFF)) begin
                err_count_q <= err_count_q + 16'd1;
            end

            // Idle counter: held in HUNT, cleared by any byte.
            if ((state_q == ST_HUNT) || rx_valid || timeout_d) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (timeout_d) begin
                state_q <= ST_HUNT;
            end else if (rx_valid) begin
                case (state_q)
                    ST_HUNT: begin
                        if (rx_byte == SYNC_BYTE) begin
                            state_q <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (rx_byte == LEN_VAL) begin
                            idx_q   <= '0;
`ifdef BLE_FRAME_CHECKSUM_EN
                            xor_q   <= rx_byte;
`endif
                            state_q <= ST_PAYLOAD;
                        end else begin
                            state_q <= ST_HUNT;
                        end
                    end
                    ST_PAYLOAD: begin
                        shadow_q[idx_q] <= rx_byte;
                        idx_q           <= idx_q + 1'b1;
`ifdef BLE_FRAME_CHECKSUM_EN
                        xor_q           <= xor_q ^ rx_byte;
                        if (last_byte_d) begin
                            state_q <= ST_CHK;
                        end
`else
                        if (last_byte_d) begin
                            state_q <= ST_HUNT;
                        end
`endif
                    end
                    default: begin
                        state_q <= ST_HUNT;
                    end
                endcase
            end
        end
    end

    assign fields      = fields_q;
    assign frame_valid = frame_valid_q;
    assign err_len     = err_len_q;
    assign err_chk     = err_chk_q;
    assign err_timeout = err_timeout_q;
    assign busy        = (state_q != ST_HUNT);
    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_ble_frame_rx.sv
// Directed testbench for ble_frame_rx: a 10x1-byte instance and a 2x2-byte
// instance, both with a short inter-byte timeout. Works with and without
// BLE_FRAME_CHECKSUM_EN (CHK bytes are only sent when it is defined).
module tb_ble_frame_rx;

    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst1, rst2;
    logic [7:0]       rx_byte1, rx_byte2;
    logic             rx_valid1, rx_valid2;
    logic [9:0][7:0]  fields1;
    logic [1:0][15:0] fields2;
    logic             fv1, el1, ec1, et1, busy1;
    logic             fv2, el2, ec2, et2, busy2;
    logic [15:0]      fc1, erc1, fc2, erc2;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int fv1_n = 0, errp1_n = 0, fv2_n = 0, errp2_n = 0;
    int exp_err = 0;
    int k;
    int fv_base;

    always #5 clk = ~clk;

    ble_frame_rx #(
        .NUM_FIELDS(10), .FIELD_BYTES(1), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TO)
    ) dut1 (
        .clk(clk), .rst(rst1), .rx_byte(rx_byte1), .rx_valid(rx_valid1),
        .fields(fields1), .frame_valid(fv1), .err_len(el1), .err_chk(ec1),
        .err_timeout(et1), .busy(busy1), .frame_count(fc1), .err_count(erc1)
    );

    ble_frame_rx #(
        .NUM_FIELDS(2), .FIELD_BYTES(2), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TO)
    ) dut2 (
        .clk(clk), .rst(rst2), .rx_byte(rx_byte2), .rx_valid(rx_valid2),
        .fields(fields2), .frame_valid(fv2), .err_len(el2), .err_chk(ec2),
        .err_timeout(et2), .busy(busy2), .frame_count(fc2), .err_count(erc2)
    );

    // Pulse monitors: each one-cycle pulse is seen at exactly one edge.
    always @(posedge clk) begin
        if (fv1) fv1_n <= fv1_n + 1;
        if (el1 || ec1 || et1) errp1_n <= errp1_n + 1;
        if (fv2) fv2_n <= fv2_n + 1;
        if (el2 || ec2 || et2) errp2_n <= errp2_n + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All byte tasks start and end on a falling edge; rx_valid stays high
    // on return so consecutive calls give back-to-back bytes.
    task automatic put1(input logic [7:0] b);
        rx_byte1 = b; rx_valid1 = 1'b1; @(negedge clk);
    endtask
    task automatic put2(input logic [7:0] b);
        rx_byte2 = b; rx_valid2 = 1'b1; @(negedge clk);
    endtask
    task automatic idle1(input int n);
        rx_valid1 = 1'b0; repeat (n) @(negedge clk);
    endtask
    task automatic chk1(input logic [7:0] b);
`ifdef BLE_FRAME_CHECKSUM_EN
        put1(b);
`else
        if (b == 8'hFF) $display("unused chk byte");
`endif
    endtask
    task automatic chk2(input logic [7:0] b);
`ifdef BLE_FRAME_CHECKSUM_EN
        put2(b);
`else
        if (b == 8'hFF) $display("unused chk byte");
`endif
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst1 = 1'b1; rst2 = 1'b1;
        rx_byte1 = '0; rx_byte2 = '0; rx_valid1 = 1'b0; rx_valid2 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_fields", fields1, 0);
        check("rst_fc", fc1, 0);
        check("rst_busy", busy1, 0);
        rst1 = 1'b0; rst2 = 1'b0;
        @(negedge clk);
        check("rst_erc", erc1, 0);
        check("rst_fv", fv1, 0);

        // Good frame; commit visible the cycle after the final byte
        $display("tx good frame 01..0A chk 01");
        put1(8'hA5); put1(8'h0A);
        for (int i = 1; i <= 10; i++) put1(8'(i));
        chk1(8'h01);
        check("good_fv", fv1, 1);
        check("good_fields", fields1, 80'h0A090807060504030201);
        check("good_f0", fields1[0], 8'h01);
        check("good_f9", fields1[9], 8'h0A);
        check("good_fc", fc1, 1);
        check("good_busy", busy1, 0);
        idle1(1);
        check("good_fv_1cyc", fv1, 0);
        check("good_no_err", errp1_n, 0);

`ifdef BLE_FRAME_CHECKSUM_EN
        // Bad checksum
        $display("tx frame 01..0A bad chk 02");
        put1(8'hA5); put1(8'h0A);
        for (int i = 1; i <= 10; i++) put1(8'(i));
        put1(8'h02);
        exp_err++;
        check("chk_err", ec1, 1);
        check("chk_fields", fields1, 80'h0A090807060504030201);
        check("chk_erc", erc1, 1);
        check("chk_fc", fc1, 1);
        idle1(1);
`else
        check("chk_tied", ec1, 0);
`endif

        // Length error, payload ignored until next sync
        $display("tx A5 0B + payload");
        put1(8'hA5); put1(8'h0B);
        exp_err++;
        check("len_err", el1, 1);
        check("len_busy", busy1, 0);
        for (int i = 1; i <= 10; i++) put1(8'(i + 8'h20));
        put1(8'h01);
        idle1(1);
        check("len_fields", fields1, 80'h0A090807060504030201);
        check("len_fc", fc1, 1);

        // LEN byte equal to SYNC_BYTE is a length error, not a resync
        $display("tx A5 A5 0A ...");
        put1(8'hA5); put1(8'hA5);
        exp_err++;
        check("len_sync_err", el1, 1);
        put1(8'h0A);
        for (int i = 1; i <= 10; i++) put1(8'h55);
        idle1(1);
        check("len_sync_fc", fc1, 1);
        check("len_erc", erc1, 16'(exp_err));

        // Timeout: pulse exactly TO clocks after the last strobe
        $display("tx A5 0A 01 02 then silence");
        put1(8'hA5); put1(8'h0A); put1(8'h01); put1(8'h02);
        idle1(0);
        check("to_busy_before", busy1, 1);
        k = 0;
        while (k < 3 * TO && !et1) begin
            @(negedge clk);
            k++;
        end
        exp_err++;
        check("to_latency", k, TO);
        check("to_pulse", et1, 1);
        check("to_busy_after", busy1, 0);
        check("to_erc", erc1, 16'(exp_err));
        idle1(1);

        // Byte on the expiry cycle wins
        $display("tx frame with %0d-clock gap", TO);
        put1(8'hA5); put1(8'h0A); put1(8'h01);
        idle1(TO - 1);
        put1(8'h02);
        idle1(0);
        check("to_byte_wins", et1, 0);
        check("to_byte_busy", busy1, 1);
        for (int i = 3; i <= 10; i++) put1(8'(i));
        chk1(8'h01);
        check("gap_fv", fv1, 1);
        check("gap_fc", fc1, 2);
        idle1(1);

        // Garbage, frame with A5/0A in payload, then back-to-back frame
        $display("tx garbage 00 FF 0A");
        fv_base = fv1_n;
        put1(8'h00); put1(8'hFF); put1(8'h0A);
        $display("tx frame A5 0A 11..88 chk 2D");
        put1(8'hA5); put1(8'h0A);
        put1(8'hA5); put1(8'h0A); put1(8'h11); put1(8'h22); put1(8'h33);
        put1(8'h44); put1(8'h55); put1(8'h66); put1(8'h77); put1(8'h88);
        chk1(8'h2D);
        $display("tx frame 10..A0 chk BA back-to-back");
        put1(8'hA5); put1(8'h0A);
        for (int i = 1; i <= 10; i++) put1(8'(i * 16));
        chk1(8'hBA);
        idle1(2);
        check("b2b_pulses", fv1_n - fv_base, 2);
        check("b2b_fields", fields1, 80'hA0908070605040302010);
        check("b2b_fc", fc1, 4);
        check("err_pulses", errp1_n, exp_err);
        check("final_erc", erc1, 16'(exp_err));

        // 2x2-byte instance
        $display("tx dut2 A5 04 12 34 AB CD chk 44");
        put2(8'hA5); put2(8'h04); put2(8'h12); put2(8'h34); put2(8'hAB); put2(8'hCD);
        chk2(8'h44);
        check("w2_fv", fv2, 1);
        check("w2_f0", fields2[0], 16'h1234);
        check("w2_f1", fields2[1], 16'hABCD);
        check("w2_fc", fc2, 1);
        rx_valid2 = 1'b0;
        @(negedge clk);

        // Reset mid-frame
        $display("tx dut2 A5 04 12 then reset");
        fv_base = fv2_n;
        put2(8'hA5); put2(8'h04); put2(8'h12);
        rx_valid2 = 1'b0;
        rst2 = 1'b1;
        #1;
        check("mrst_fields", fields2, 0);
        check("mrst_fc", fc2, 0);
        check("mrst_busy", busy2, 0);
        check("mrst_fv", fv2, 0);
        @(negedge clk);
        @(negedge clk);
        rst2 = 1'b0;
        put2(8'h34); put2(8'hAB); put2(8'hCD);
        rx_valid2 = 1'b0;
        repeat (TO + 4) @(negedge clk);
        check("mrst_no_fv", fv2_n - fv_base, 0);
        check("mrst_no_err", errp2_n, 0);
        check("mrst_erc", erc2, 0);
        check("mrst_fields_after", fields2, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
